// File: rtl/serial_subtractor_16bit.sv
// serial_subtractor_16bit
// Digit-serial subtractor that computes Diff = A - B - Bin, one DIGIT-wide
// slice per clock, starting at the least significant slice. A request is
// taken with start when the block is idle or has just finished. busy is high
// while slices are being processed. done pulses for one cycle when the result
// is complete.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous, active-high reset
//   start in   request, accepted in IDLE or DONE
//   A     in   WIDTH-bit minuend, latched on the accepting edge
//   B     in   WIDTH-bit subtrahend, latched on the accepting edge
//   Bin   in   borrow-in, latched on the accepting edge
//   busy  out  high while the FSM is in RUN
//   done  out  one-cycle pulse; results are valid from here on
//   Diff  out  (A - B - Bin) mod 2^WIDTH
//   Bout  out  final borrow, 1 iff A < B + Bin (unsigned)
//   Zero  out  1 iff Diff == 0
//   Ovf   out  two's-complement overflow of the subtraction
module serial_subtractor_16bit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero,
    output logic             Ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_borrow;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_zero;
    logic             r_ovf;

    int               w_base;
    logic [DIGIT-1:0] w_aSlice;
    logic [DIGIT-1:0] w_bSlice;
    logic [DIGIT:0]   w_step;
    logic [WIDTH-1:0] w_diffNext;
    logic             w_zeroNext;
    logic             w_ovfNext;

    // One digit step of the subtraction. The slice is subtracted over DIGIT+1
    // bits so that the top bit is the borrow out of this slice. w_diffNext is
    // the result register with the current slice replaced. On the final step
    // it is the complete result, so Zero and Ovf can be taken from it
    // directly.
    always_comb begin
        w_base     = int'(r_cnt) * DIGIT;
        w_aSlice   = r_a[w_base +: DIGIT];
        w_bSlice   = r_b[w_base +: DIGIT];
        w_step     = {1'b0, w_aSlice} - {1'b0, w_bSlice} - {{DIGIT{1'b0}}, r_borrow};
        w_diffNext = r_diff;
        w_diffNext[w_base +: DIGIT] = w_step[DIGIT-1:0];
        w_zeroNext = (w_diffNext == '0);
        w_ovfNext  = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                     (w_diffNext[WIDTH-1] != r_a[WIDTH-1]);
    end

    // Control FSM and datapath registers. In IDLE and DONE a start latches
    // the operands. DONE also returns directly to RUN for back-to-back
    // operation. The flags change only on the last RUN edge, so they keep
    // the previous result's values while a new operation is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_borrow <= Bin;
                        r_cnt    <= '0;
                        r_state  <= RUN;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                RUN: begin
                    r_diff   <= w_diffNext;
                    r_borrow <= w_step[DIGIT];
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_bout  <= w_step[DIGIT];
                        r_zero  <= w_zeroNext;
                        r_ovf   <= w_ovfNext;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign Diff = r_diff;
    assign Bout = r_bout;
    assign Zero = r_zero;
    assign Ovf  = r_ovf;

endmodule
